// File: rtl/clause_bin_ctrl_if.sv
// Signal bundle between one clause-bin controller and its surroundings: the clause
// load channel, the BCP variable vectors, and the status/backtrack pulses.
interface clause_bin_ctrl_if #(
    parameter int NUM_CLAUSES_A_BIN = 4,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int WIDTH_C_LEN       = 5
);
    logic                            load_start;
    logic                            cl_valid;
    logic                            cl_ready;
    logic [WIDTH_C_LEN-1:0]          cl_len;
    logic                            cl_last;
    logic [NUM_CLAUSES_A_BIN-1:0]    wr;
    logic [WIDTH_C_LEN-1:0]          clause_len;
    logic                            bcp_start;
    logic [3*NUM_VARS_A_BIN-1:0]     var_value_init;
    logic [3*NUM_VARS_A_BIN-1:0]     var_value_frombase;
    logic [3*NUM_VARS_A_BIN-1:0]     var_value_tobase;
    logic                            bcp_done;
    logic                            conflict;
    logic                            timeout;
    logic                            backtrack;
    logic                            apply_backtrack;
    logic                            busy;

    modport master (
        output load_start, cl_valid, cl_len, cl_last, bcp_start,
               var_value_init, var_value_tobase, backtrack,
        input  cl_ready, wr, clause_len, var_value_frombase,
               bcp_done, conflict, timeout, apply_backtrack, busy
    );

    modport slave (
        input  load_start, cl_valid, cl_len, cl_last, bcp_start,
               var_value_init, var_value_tobase, backtrack,
        output cl_ready, wr, clause_len, var_value_frombase,
               bcp_done, conflict, timeout, apply_backtrack, busy
    );
endinterface

// File: rtl/clause_bin_ctrl.sv
// Clause-bin controller: loads clauses slot by slot, iterates BCP through the bin until
// fixpoint / conflict / iteration limit, and issues the single-cycle backtrack pulse.
module clause_bin_ctrl #(
    parameter int NUM_CLAUSES_A_BIN = 4,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int WIDTH_C_LEN       = 5,
    parameter int MAX_ITER          = 16
) (
    input logic              clk,
    input logic              rst,
    clause_bin_ctrl_if.slave bus
);
    localparam int PTR_W  = (NUM_CLAUSES_A_BIN > 1) ? $clog2(NUM_CLAUSES_A_BIN) : 1;
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int VEC_W  = 3 * NUM_VARS_A_BIN;
    localparam logic [NUM_CLAUSES_A_BIN-1:0] WR_BASE = {{(NUM_CLAUSES_A_BIN-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(NUM_CLAUSES_A_BIN - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_BCP  = 3'd2,
        ST_DONE = 3'd3,
        ST_BT   = 3'd4
    } state_t;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [PTR_W-1:0]               ptr_r;
    logic [ITER_W-1:0]              iter_r;
    logic [VEC_W-1:0]               frombase_r;
    logic                           conflict_r;
    logic                           timeout_r;
    logic                           conflict_s;
    logic                           fixpoint_s;
    logic                           last_iter_s;
    logic                           slot_full_s;
    logic [NUM_CLAUSES_A_BIN-1:0]   wr_s;
    logic [WIDTH_C_LEN-1:0]         clause_len_s;

    // A field whose value bits are both set marks a contradiction on that variable.
    function automatic logic any_conflict(input logic [VEC_W-1:0] v);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
            hit = hit | (v[3*k +: 2] == 2'b11);
        end
        return hit;
    endfunction

    assign conflict_s  = any_conflict(bus.var_value_tobase);
    assign fixpoint_s  = (bus.var_value_tobase == frombase_r);
    assign last_iter_s = (iter_r == LAST_ITER);
    assign slot_full_s = (ptr_r == LAST_SLOT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and the per-beat slot write strobe.
    always_comb begin
        state_nxt_s  = state_r;
        wr_s         = {NUM_CLAUSES_A_BIN{1'b0}};
        clause_len_s = {WIDTH_C_LEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (bus.backtrack) begin
                    state_nxt_s = ST_BT;
                end else if (bus.bcp_start) begin
                    state_nxt_s = ST_BCP;
                end else if (bus.load_start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.cl_valid) begin
                    wr_s         = WR_BASE << ptr_r;
                    clause_len_s = bus.cl_len;
                    if (bus.cl_last || slot_full_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_BCP: begin
                if (conflict_s || fixpoint_s || last_iter_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BCP;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_BT:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: slot pointer, iteration count, vector register and result flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r      <= {PTR_W{1'b0}};
            iter_r     <= {ITER_W{1'b0}};
            frombase_r <= {VEC_W{1'b0}};
            conflict_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.backtrack) begin
                        conflict_r <= 1'b0;
                        timeout_r  <= 1'b0;
                    end else if (bus.bcp_start) begin
                        frombase_r <= bus.var_value_init;
                        iter_r     <= {ITER_W{1'b0}};
                        conflict_r <= 1'b0;
                        timeout_r  <= 1'b0;
                    end else if (bus.load_start) begin
                        ptr_r <= {PTR_W{1'b0}};
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_LOAD: begin
                    // The pointer parks on the last slot; the load ends there anyway.
                    if (bus.cl_valid && !slot_full_s) begin
                        ptr_r <= ptr_r + PTR_W'(1);
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_BCP: begin
                    iter_r <= iter_r + ITER_W'(1);
                    if (conflict_s) begin
                        conflict_r <= 1'b1;
                    end else if (fixpoint_s) begin
                        frombase_r <= frombase_r;
                    end else if (last_iter_s) begin
                        timeout_r <= 1'b1;
                    end else begin
                        frombase_r <= bus.var_value_tobase;
                    end
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

    assign bus.cl_ready           = (state_r == ST_LOAD);
    assign bus.wr                 = wr_s;
    assign bus.clause_len         = clause_len_s;
    assign bus.var_value_frombase = frombase_r;
    assign bus.bcp_done           = (state_r == ST_DONE);
    assign bus.conflict           = conflict_r;
    assign bus.timeout            = timeout_r;
    assign bus.apply_backtrack    = (state_r == ST_BT);
    assign bus.busy               = (state_r != ST_IDLE);
endmodule
